// File: rtl/alu_pkg.sv
// Shared encodings for the serial ALU command controller: command ops, slice ops, FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  localparam logic [1:0] SLICE_AND = 2'b00;
  localparam logic [1:0] SLICE_OR  = 2'b01;
  localparam logic [1:0] SLICE_ADD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Serial W-bit ALU controller: runs each command as NIBBLES low-first passes through an external
// 4-bit slice, chaining carry, and returns result plus flags on a valid/ready response port.
//
// state   | meaning
// ST_IDLE | cmd_ready high, waiting for a command
// ST_RUN  | one slice pass per cycle, nibble r_idx
// ST_RESP | response held on rsp_* until rsp_ready
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [4*NIBBLES-1:0] cmd_a,
  input  logic [4*NIBBLES-1:0] cmd_b,
  input  logic                 cmd_cin,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [1:0]           alu_op,
  output logic                 alu_cin,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cout,
  input  logic                 alu_overflow,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_result,
  output logic                 rsp_cout,
  output logic                 rsp_zero,
  output logic                 rsp_overflow,
  output logic                 rsp_negative
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_e          r_state;
  op_e             r_op;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;
  logic            r_neg;

  logic            w_run;
  logic            w_logic_op;
  logic [IDXW+1:0] w_shift;
  logic [3:0]      w_nib_a;
  logic [3:0]      w_nib_b;
  logic [W-1:0]    w_res_next;

  assign w_run      = (r_state == ST_RUN);
  assign w_logic_op = (r_op == OP_AND) || (r_op == OP_OR);
  assign w_shift    = {r_idx, 2'b00};

  always_comb begin
    w_nib_a    = 4'(r_a >> w_shift);
    w_nib_b    = 4'(r_b >> w_shift);
    w_res_next = (r_res & ~(W'(4'hF) << w_shift)) | (W'(alu_f) << w_shift);
  end

  // Slice drive is combinational off registered state so each pass settles within one cycle.
  assign alu_a     = w_run ? w_nib_a : 4'h0;
  assign alu_b     = w_run ? ((r_op == OP_SUB) ? ~w_nib_b : w_nib_b) : 4'h0;
  assign alu_op    = w_run ? ((r_op == OP_SUB) ? SLICE_ADD : r_op) : 2'b00;
  assign alu_cin   = w_run ? r_carry : 1'b0;

  assign cmd_ready    = (r_state == ST_IDLE);
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_result   = r_res;
  assign rsp_cout     = r_cout;
  assign rsp_zero     = r_zero;
  assign rsp_overflow = r_ovf;
  assign rsp_negative = r_neg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_AND;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= op_e'(cmd_op);
            r_a     <= cmd_a;
            r_b     <= cmd_b;
            r_idx   <= '0;
            r_carry <= (op_e'(cmd_op) == OP_SUB) ? 1'b1 :
                       (op_e'(cmd_op) == OP_ADD) ? cmd_cin : 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_next;
          r_carry <= alu_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_logic_op ? 1'b0 : alu_cout;
            r_ovf   <= w_logic_op ? 1'b0 : alu_overflow;
            r_zero  <= (w_res_next == '0);
            r_neg   <= w_res_next[W-1];
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with NIBBLES=2 and a behavioural 4-bit slice model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_cin = 1'b0;
  logic [3:0] alu_a, alu_b, alu_f;
  logic [1:0] alu_op;
  logic       alu_cin, alu_cout, alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_cout, rsp_zero, rsp_overflow, rsp_negative;

  logic       force_flags = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NIBBLES(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_negative(rsp_negative)
  );

  // Slice model; force_flags makes AND/OR report cout/overflow high to prove the controller masks them.
  logic [4:0] m_sum;
  logic [3:0] m_low;
  always_comb begin
    m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
    m_low = {1'b0, alu_a[2:0]} + {1'b0, alu_b[2:0]} + {3'b0, alu_cin};
    case (alu_op)
      2'b00:   begin alu_f = alu_a & alu_b; alu_cout = force_flags; alu_overflow = force_flags; end
      2'b01:   begin alu_f = alu_a | alu_b; alu_cout = force_flags; alu_overflow = force_flags; end
      default: begin alu_f = m_sum[3:0]; alu_cout = m_sum[4]; alu_overflow = m_low[3] ^ m_sum[4]; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin);
    @(negedge clk);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Full transaction: accept, check pass-0 slice drive, check latency, check response, drain.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [3:0] exp_b0,
                         input logic exp_cin0, input logic [7:0] res, input logic cout,
                         input logic ovf, input logic zero, input logic neg);
    accept(op, a, b, cin);
    chk({tag, "_alu_a0"},   {28'b0, alu_a}, {28'b0, a[3:0]});
    chk({tag, "_alu_b0"},   {28'b0, alu_b}, {28'b0, exp_b0});
    chk({tag, "_alu_op"},   {30'b0, alu_op}, (op == 2'b11) ? 32'd2 : {30'b0, op});
    chk({tag, "_alu_cin0"}, {31'b0, alu_cin}, {31'b0, exp_cin0});
    chk({tag, "_cmd_ready_run"}, {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rsp_valid_early"}, {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, "_result"},    {24'b0, rsp_result}, {24'b0, res});
    chk({tag, "_cout"},      {31'b0, rsp_cout}, {31'b0, cout});
    chk({tag, "_ovf"},       {31'b0, rsp_overflow}, {31'b0, ovf});
    chk({tag, "_zero"},      {31'b0, rsp_zero}, {31'b0, zero});
    chk({tag, "_neg"},       {31'b0, rsp_negative}, {31'b0, neg});
    chk({tag, "_alu_idle"},  {26'b0, alu_a, alu_op}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int waited;
    #12;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp", {20'b0, rsp_valid, rsp_result, rsp_cout, rsp_zero, rsp_overflow, rsp_negative}, 32'd0);
    chk("rst_alu", {21'b0, alu_a, alu_b, alu_op, alu_cin}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_cmd("add7f01", 2'b10, 8'h7F, 8'h01, 1'b0, 4'h1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    run_cmd("sub0505", 2'b11, 8'h05, 8'h05, 1'b0, 4'hA, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run_cmd("sub0305", 2'b11, 8'h03, 8'h05, 1'b0, 4'hA, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_cmd("addff00", 2'b10, 8'hFF, 8'h00, 1'b1, 4'h0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    force_flags = 1'b1;
    run_cmd("and",     2'b00, 8'hF0, 8'h3C, 1'b1, 4'hC, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    run_cmd("or",      2'b01, 8'hF0, 8'h3C, 1'b1, 4'hC, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1);
    force_flags = 1'b0;

    // Backpressure: hold response 5 cycles while a second command waits.
    accept(2'b10, 8'h12, 8'h34, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    cmd_op = 2'b11; cmd_a = 8'h10; cmd_b = 8'h01; cmd_cin = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_hold_result", {24'b0, rsp_result}, 32'h46);
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_second_accepted", {31'b0, cmd_ready}, 32'd0);
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("bp_second_latency", waited, 32'd2);
    chk("bp_second_result", {24'b0, rsp_result}, 32'h0F);
    chk("bp_second_cout", {31'b0, rsp_cout}, 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset after pass 0 of an in-flight command.
    accept(2'b10, 8'h11, 8'h22, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("midrst_alu", {21'b0, alu_a, alu_b, alu_op, alu_cin}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
